// File: rtl/lsu_pkg.sv
// Shared address map, access-size encodings and byte-merge helper for the load-store unit.
// No latency or flow control of its own; pure declarations.
// Optional misalignment checking is selected by LSU_MISALIGN_CHK_EN in lsu.sv.
package lsu_pkg;

   localparam logic [15:0] DMEM_END    = 16'h07FF;
   localparam logic [15:0] LEDR_ADDR   = 16'h7000;
   localparam logic [15:0] LEDG_ADDR   = 16'h7010;
   localparam logic [15:0] HEX_LO_ADDR = 16'h7020;
   localparam logic [15:0] HEX_HI_ADDR = 16'h7024;
   localparam logic [15:0] LCD_ADDR    = 16'h7030;
   localparam logic [15:0] SW_ADDR     = 16'h7800;
   localparam logic [15:0] BTN_ADDR    = 16'h7810;

   typedef enum logic [2:0] {
      MEM_B  = 3'd0,
      MEM_H  = 3'd1,
      MEM_W  = 3'd2,
      MEM_BU = 3'd4,
      MEM_HU = 3'd5
   } mem_size_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Word-organised data memory: byte-enable write on the clock edge, asynchronous read.
// Write latency one edge, read combinational; no backpressure.
// Contents are deliberately not reset.
module lsu_dmem #(
   parameter int AW = 11
) (
   input  logic          clk_i,
   input  logic [3:0]    be_i,
   input  logic [AW-3:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [2**(AW-2)];

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
   end

   assign rdata_o = mem[addr_i];

endmodule

// File: rtl/lsu.sv
// Load-store unit: data memory plus memory-mapped LED/HEX/LCD registers and synchronised switches/buttons.
// Stores commit on the rising edge, loads return combinationally; never stalls the core.
// Define LSU_MISALIGN_CHK_EN to suppress misaligned accesses and raise a sticky misalign_o flag.
module lsu
   import lsu_pkg::*;
#(
   parameter int DMEM_AW  = 11,
   parameter int SYNC_STG = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   input  logic        lsu_wr_en_i,
   input  logic        lsu_rd_en_i,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   input  logic [17:0] sw_i,
   input  logic [3:0]  btn_i,
   output logic [16:0] ledr_o,
   output logic [7:0]  ledg_o,
   output logic [55:0] hex_o,
   output logic [31:0] lcd_o
);

   logic [15:0] a;
   mem_size_e   size;
   logic        sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw, sel_btn;
   logic [3:0]  be, wr_be;
   logic        misal;
   logic [31:0] wd, rword, ld, dmem_rdata;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ledr_nxt, ledg_nxt, hex_lo_nxt, hex_hi_nxt, lcd_nxt;
   logic [16:0] ledr_q;
   logic [7:0]  ledg_q;
   logic [55:0] hex_q;
   logic [31:0] lcd_q;
   logic [17:0] sw_ff  [SYNC_STG];
   logic [3:0]  btn_ff [SYNC_STG];
   logic        unused_ok;

   assign a    = addr_i[15:0];
   assign size = mem_size_e'(funct3_i);

   always_comb begin
      sel_dmem   = (a <= DMEM_END);
      sel_ledr   = (a[15:2] == LEDR_ADDR[15:2]);
      sel_ledg   = (a[15:2] == LEDG_ADDR[15:2]);
      sel_hex_lo = (a[15:2] == HEX_LO_ADDR[15:2]);
      sel_hex_hi = (a[15:2] == HEX_HI_ADDR[15:2]);
      sel_lcd    = (a[15:2] == LCD_ADDR[15:2]);
      sel_sw     = (a[15:2] == SW_ADDR[15:2]);
      sel_btn    = (a[15:2] == BTN_ADDR[15:2]);
   end

   // Store data is replicated across lanes so the byte enables alone pick the target lane.
   always_comb begin
      be    = 4'b0000;
      misal = 1'b0;
      wd    = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be = 4'b0001 << a[1:0];
            wd = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be    = a[1] ? 4'b1100 : 4'b0011;
            misal = a[0];
            wd    = {2{wdata_i[15:0]}};
         end
         2'b10: begin
            be    = 4'b1111;
            misal = |a[1:0];
         end
         default: be = 4'b0000;
      endcase
   end

`ifdef LSU_MISALIGN_CHK_EN
   assign wr_be = (lsu_wr_en_i && rst_ni && !misal) ? be : 4'b0000;
`else
   assign wr_be = (lsu_wr_en_i && rst_ni) ? be : 4'b0000;
`endif

   lsu_dmem #(.AW(DMEM_AW)) u_dmem (
      .clk_i   (clk_i),
      .be_i    (sel_dmem ? wr_be : 4'b0000),
      .addr_i  (a[DMEM_AW-1:2]),
      .wdata_i (wd),
      .rdata_o (dmem_rdata)
   );

   assign ledr_nxt   = merge_bytes({15'b0, ledr_q}, wd, wr_be);
   assign ledg_nxt   = merge_bytes({24'b0, ledg_q}, wd, wr_be);
   assign hex_lo_nxt = merge_bytes({4'b0, hex_q[27:0]}, wd, wr_be);
   assign hex_hi_nxt = merge_bytes({4'b0, hex_q[55:28]}, wd, wr_be);
   assign lcd_nxt    = merge_bytes(lcd_q, wd, wr_be);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ledr_q <= '0;
         ledg_q <= '0;
         hex_q  <= '0;
         lcd_q  <= '0;
      end else begin
         if (sel_ledr)   ledr_q        <= ledr_nxt[16:0];
         if (sel_ledg)   ledg_q        <= ledg_nxt[7:0];
         if (sel_hex_lo) hex_q[27:0]   <= hex_lo_nxt[27:0];
         if (sel_hex_hi) hex_q[55:28]  <= hex_hi_nxt[27:0];
         if (sel_lcd)    lcd_q         <= lcd_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SYNC_STG; i++) begin
            sw_ff[i]  <= '0;
            btn_ff[i] <= '1;
         end
      end else begin
         sw_ff[0]  <= sw_i;
         btn_ff[0] <= btn_i;
         for (int i = 1; i < SYNC_STG; i++) begin
            sw_ff[i]  <= sw_ff[i-1];
            btn_ff[i] <= btn_ff[i-1];
         end
      end
   end

   always_comb begin
      rword = '0;
      if (sel_dmem)        rword = dmem_rdata;
      else if (sel_ledr)   rword = {15'b0, ledr_q};
      else if (sel_ledg)   rword = {24'b0, ledg_q};
      else if (sel_hex_lo) rword = {4'b0, hex_q[27:0]};
      else if (sel_hex_hi) rword = {4'b0, hex_q[55:28]};
      else if (sel_lcd)    rword = lcd_q;
      else if (sel_sw)     rword = {14'b0, sw_ff[SYNC_STG-1]};
      else if (sel_btn)    rword = {28'b0, ~btn_ff[SYNC_STG-1]};
   end

   always_comb begin
      case (a[1:0])
         2'd0:    ld_b = rword[7:0];
         2'd1:    ld_b = rword[15:8];
         2'd2:    ld_b = rword[23:16];
         default: ld_b = rword[31:24];
      endcase
      ld_h = a[1] ? rword[31:16] : rword[15:0];
      case (size)
         MEM_B:   ld = {{24{ld_b[7]}}, ld_b};
         MEM_BU:  ld = {24'b0, ld_b};
         MEM_H:   ld = {{16{ld_h[15]}}, ld_h};
         MEM_HU:  ld = {16'b0, ld_h};
         MEM_W:   ld = rword;
         default: ld = '0;
      endcase
   end

`ifdef LSU_MISALIGN_CHK_EN
   logic misalign_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) misalign_q <= 1'b0;
      else         misalign_q <= misalign_q | ((lsu_wr_en_i | lsu_rd_en_i) & misal);
   end

   assign misalign_o = misalign_q;
   assign rdata_o    = (lsu_rd_en_i && rst_ni && !misal) ? ld : 32'h0;
`else
   assign misalign_o = 1'b0;
   assign rdata_o    = (lsu_rd_en_i && rst_ni) ? ld : 32'h0;
`endif

   assign ledr_o = ledr_q;
   assign ledg_o = ledg_q;
   assign hex_o  = hex_q;
   assign lcd_o  = lcd_q;

   assign unused_ok = ^{addr_i[31:16], misal, ledr_nxt[31:17], ledg_nxt[31:8],
                        hex_lo_nxt[31:28], hex_hi_nxt[31:28]};

endmodule
